// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared states, constants and the byte-wise USB CRC16 step.
package usb_tx_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, IDLE_J} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [6:0] MAX_DATA_LEN = 7'd64;
  localparam int EOP_BITS = 2;
  localparam logic [1:0] HANDSHAKE_TYPE = 2'b10;
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ CRC16_POLY_REFL : r >> 1;
    return r;
  endfunction
endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: byte-wise USB CRC16 accumulator with synchronous clear.
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) crc <= CRC16_INIT;
    else if (clear) crc <= CRC16_INIT;
    else if (en) crc <= crc16_byte(crc, data);
endmodule

// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: USB packet transmit sequencer (SYNC, PID, data, CRC16, EOP).
// Define USB_TX_UNDERRUN_ABORT_EN to abort on FIFO underrun instead of stalling.
module usb_tx_ctrl
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_data_len,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  input  logic       byte_done,
  input  logic       bit_strobe,
  output logic       fifo_pop,
  output logic [7:0] tx_byte,
  output logic       load_byte,
  output logic       timer_en,
  output logic       timer_clear,
  output logic       eop,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);
  state_t state, nxt;
  logic [3:0] pid;
  logic [6:0] rem, rem_n;
  logic stall, stall_n, ecnt, ecnt_n, dl, crc_clr, crc_en;
  logic [15:0] crc;
  wire [6:0] len_c = tx_data_len > MAX_DATA_LEN ? MAX_DATA_LEN : tx_data_len;
  wire hs = pid[1:0] == HANDSHAKE_TYPE;
  usb_crc16 u_crc (.clk(clk), .rst(rst), .clear(crc_clr), .en(crc_en), .data(fifo_rdata), .crc(crc));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pid <= 4'h0;
      rem <= 7'd0;
      stall <= 1'b0;
      ecnt <= 1'b0;
    end else begin
      state <= nxt;
      rem <= rem_n;
      stall <= stall_n;
      ecnt <= ecnt_n;
      if (state == IDLE && tx_start) pid <= tx_pid;
    end
  always_comb begin
    nxt = state;
    rem_n = rem;
    stall_n = stall;
    ecnt_n = ecnt;
    dl = 1'b0;
    fifo_pop = 1'b0;
    tx_byte = 8'h00;
    load_byte = 1'b0;
    timer_en = state != IDLE;
    timer_clear = 1'b0;
    eop = 1'b0;
    tx_busy = state != IDLE;
    tx_done = 1'b0;
    tx_error = 1'b0;
    crc_clr = 1'b0;
    crc_en = 1'b0;
    case (state)
      IDLE: if (tx_start) begin
        nxt = SYNC;
        timer_clear = 1'b1;
        load_byte = 1'b1;
        tx_byte = SYNC_BYTE;
        rem_n = len_c;
        stall_n = 1'b0;
        ecnt_n = 1'b0;
        crc_clr = 1'b1;
      end
      SYNC: if (byte_done) begin
        nxt = PID;
        load_byte = 1'b1;
        tx_byte = {~pid, pid};
      end
      PID, DATA: if (stall || byte_done) begin
        if (state == PID && hs) nxt = EOP;
        else if (rem == 7'd0) begin
          nxt = CRC_LO;
          load_byte = 1'b1;
          tx_byte = ~crc[7:0];
        end else dl = 1'b1;
      end
      CRC_LO: if (byte_done) begin
        nxt = CRC_HI;
        load_byte = 1'b1;
        tx_byte = ~crc[15:8];
      end
      CRC_HI: if (byte_done) nxt = EOP;
      EOP: begin
        eop = 1'b1;
        if (bit_strobe) begin
          ecnt_n = ecnt + 1'b1;
          if (ecnt == 1'(EOP_BITS - 1)) begin
            nxt = IDLE_J;
            ecnt_n = 1'b0;
          end
        end
      end
      IDLE_J: if (bit_strobe) begin
        tx_done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // A data load point: either take the FIFO head or handle the underrun.
    if (dl) begin
      if (fifo_empty) begin
`ifdef USB_TX_UNDERRUN_ABORT_EN
        tx_error = 1'b1;
        stall_n = 1'b0;
        nxt = EOP;
`else
        timer_en = 1'b0;
        stall_n = 1'b1;
`endif
      end else begin
        load_byte = 1'b1;
        fifo_pop = 1'b1;
        tx_byte = fifo_rdata;
        rem_n = rem - 7'd1;
        crc_en = 1'b1;
        stall_n = 1'b0;
        nxt = DATA;
      end
    end
  end
endmodule

// File: tb/tb_usb_tx_ctrl.sv
// tb_usb_tx_ctrl: self-checking bench with bit-timer and FIFO models and a packet-level reference.
module tb_usb_tx_ctrl;
  logic clk = 1'b0, rst = 1'b1, tx_start = 1'b0;
  logic [3:0] tx_pid = 4'h0;
  logic [6:0] tx_data_len = 7'd0;
  logic [7:0] fifo_rdata, tx_byte;
  logic fifo_empty, byte_done, bit_strobe;
  logic fifo_pop, load_byte, timer_en, timer_clear, eop, tx_busy, tx_done, tx_error;
  logic [3:0] tcnt;
  logic [7:0] fq[$], dq[$], loads[$], exp_q[$];
  int pops, dones, errs, eops;
  bit saw_low;
  int errors = 0, checks = 0;

  usb_tx_ctrl dut (.clk(clk), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid), .tx_data_len(tx_data_len),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .byte_done(byte_done), .bit_strobe(bit_strobe),
    .fifo_pop(fifo_pop), .tx_byte(tx_byte), .load_byte(load_byte), .timer_en(timer_en),
    .timer_clear(timer_clear), .eop(eop), .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error));

  always #5 clk = ~clk;

  // Bit timer: one bit every 2 clocks, byte flag on the 16th count.
  always @(posedge clk or posedge rst)
    if (rst) tcnt <= 4'd0;
    else if (timer_clear) tcnt <= 4'd0;
    else if (timer_en) tcnt <= tcnt + 4'd1;
  assign bit_strobe = tcnt[0];
  assign byte_done = tcnt == 4'hF;

  always_comb begin
    fifo_empty = fq.size() == 0;
    fifo_rdata = fifo_empty ? 8'h00 : fq[0];
  end
  always @(posedge clk) if (fifo_pop && fq.size() != 0) void'(fq.pop_front());

  always @(negedge clk) if (!rst) begin
    if (load_byte) loads.push_back(tx_byte);
    if (fifo_pop) pops++;
    if (tx_done) dones++;
    if (tx_error) errs++;
    if (eop && bit_strobe) eops++;
    if (tx_busy && !timer_en) saw_low = 1'b1;
  end

  function automatic void model(input logic [3:0] p, input int len);
    logic [15:0] c = 16'hFFFF;
    int n = len > 64 ? 64 : len;
    exp_q.delete();
    exp_q.push_back(8'h80);
    exp_q.push_back({~p, p});
    if (p[1:0] != 2'b10) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(dq[i]);
        for (int k = 0; k < 8; k++) begin
          logic fb = c[0] ^ dq[i][k];
          c = c >> 1;
          if (fb) c = c ^ 16'hA001;
        end
      end
      exp_q.push_back(~c[7:0]);
      exp_q.push_back(~c[15:8]);
    end
  endfunction

  function automatic int mism();
    int m = 0;
    if (loads.size() != exp_q.size()) return 1000;
    foreach (exp_q[i]) if (loads[i] !== exp_q[i]) m++;
    return m;
  endfunction

  task automatic fill(input int len);
    dq.delete();
    for (int i = 0; i < len; i++) dq.push_back(8'($urandom));
    fq = dq;
  endtask

  task automatic start_pkt(input logic [3:0] p, input int len);
    loads.delete();
    pops = 0; dones = 0; errs = 0; eops = 0; saw_low = 1'b0;
    @(posedge clk); #1;
    tx_pid = p; tx_data_len = 7'(len); tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (dones == 0 && t < 5000) begin @(negedge clk); t++; end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({fifo_pop, tx_byte, load_byte, timer_en, timer_clear, eop, tx_busy, tx_done, tx_error} !== 16'h0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", {fifo_pop, tx_byte, load_byte, timer_en, timer_clear, eop, tx_busy, tx_done, tx_error});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b want=0", tx_busy); end
  endtask

  task automatic test_ack();
    fq.delete();
    start_pkt(4'b0010, 5);
    wait_done();
    exp_q.delete(); exp_q.push_back(8'h80); exp_q.push_back(8'hD2);
    checks++; if (mism() != 0) begin errors++; $display("FAIL ack_loads got_n=%0d want_n=2 first=%h", loads.size(), loads.size() ? loads[0] : 8'h0); end
    checks++; if (pops != 0) begin errors++; $display("FAIL ack_pops got=%0d want=0", pops); end
    checks++; if (eops != 2) begin errors++; $display("FAIL ack_eop_bits got=%0d want=2", eops); end
    checks++; if (dones != 1) begin errors++; $display("FAIL ack_done got=%0d want=1", dones); end
  endtask

  task automatic test_data0_empty();
    fq.delete();
    start_pkt(4'b0011, 0);
    wait_done();
    exp_q.delete();
    exp_q.push_back(8'h80); exp_q.push_back(8'hC3); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    checks++; if (mism() != 0) begin errors++; $display("FAIL data0_loads got_n=%0d want_n=4", loads.size()); end
    checks++; if (eops != 2) begin errors++; $display("FAIL data0_eop_bits got=%0d want=2", eops); end
    checks++; if (dones != 1) begin errors++; $display("FAIL data0_done got=%0d want=1", dones); end
  endtask

  task automatic test_data1_three();
    dq.delete(); dq.push_back(8'h01); dq.push_back(8'h02); dq.push_back(8'h03);
    fq = dq;
    start_pkt(4'b1011, 3);
    wait_done();
    model(4'b1011, 3);
    checks++; if (mism() != 0) begin errors++; $display("FAIL data1_loads got_n=%0d want_n=%0d mism=%0d", loads.size(), exp_q.size(), mism()); end
    checks++; if (loads.size() > 2 && loads[1] !== 8'h4B) begin errors++; $display("FAIL data1_pid got=%h want=4b", loads[1]); end
    checks++; if (pops != 3) begin errors++; $display("FAIL data1_pops got=%0d want=3", pops); end
    checks++; if (dones != 1 || errs != 0) begin errors++; $display("FAIL data1_done got=%0d/%0d want=1/0", dones, errs); end
  endtask

  task automatic test_clamp();
    fill(100);
    start_pkt(4'b0011, 100);
    wait_done();
    model(4'b0011, 100);
    checks++; if (pops != 64) begin errors++; $display("FAIL clamp_pops got=%0d want=64", pops); end
    checks++; if (mism() != 0) begin errors++; $display("FAIL clamp_loads got_n=%0d want_n=%0d", loads.size(), exp_q.size()); end
    checks++; if (dones != 1) begin errors++; $display("FAIL clamp_done got=%0d want=1", dones); end
    fq.delete();
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [3:0] p = 4'($urandom);
      int len = $urandom_range(0, 70);
      int n = p[1:0] == 2'b10 ? 0 : (len > 64 ? 64 : len);
      fill(len);
      start_pkt(p, len);
      repeat (20) @(negedge clk);
      @(posedge clk); #1 tx_pid = ~p; tx_start = 1'b1;
      @(posedge clk); #1 tx_start = 1'b0;
      wait_done();
      model(p, len);
      checks++; if (mism() != 0) begin errors++; $display("FAIL rand%0d_loads pid=%h len=%0d got_n=%0d want_n=%0d", r, p, len, loads.size(), exp_q.size()); end
      checks++; if (pops != n) begin errors++; $display("FAIL rand%0d_pops got=%0d want=%0d", r, pops, n); end
      checks++; if (dones != 1 || eops != 2) begin errors++; $display("FAIL rand%0d_done got=%0d eop=%0d want=1/2", r, dones, eops); end
      checks++; if (saw_low || errs != 0) begin errors++; $display("FAIL rand%0d_timer got_low=%b err=%0d want=0/0", r, saw_low, errs); end
      fq.delete();
    end
  endtask

  task automatic test_underrun();
    int t = 0;
    fill(3);
    fq.delete(); fq.push_back(dq[0]);
    start_pkt(4'b0011, 3);
    while (pops < 1 && t < 1000) begin @(negedge clk); t++; end
    repeat (48) @(negedge clk);
`ifdef USB_TX_UNDERRUN_ABORT_EN
    wait_done();
    exp_q.delete(); exp_q.push_back(8'h80); exp_q.push_back(8'hC3); exp_q.push_back(dq[0]);
    checks++; if (errs != 1) begin errors++; $display("FAIL underrun_error got=%0d want=1", errs); end
    checks++; if (mism() != 0) begin errors++; $display("FAIL underrun_loads got_n=%0d want_n=3", loads.size()); end
    checks++; if (pops != 1 || eops != 2) begin errors++; $display("FAIL underrun_pops_eop got=%0d/%0d want=1/2", pops, eops); end
    checks++; if (dones != 1) begin errors++; $display("FAIL underrun_done got=%0d want=1", dones); end
`else
    checks++; if (!saw_low || dones != 0 || !tx_busy) begin errors++; $display("FAIL underrun_stall got_low=%b done=%0d busy=%b want=1/0/1", saw_low, dones, tx_busy); end
    @(posedge clk); #1 fq.push_back(dq[1]); fq.push_back(dq[2]);
    wait_done();
    model(4'b0011, 3);
    checks++; if (mism() != 0) begin errors++; $display("FAIL underrun_loads got_n=%0d want_n=%0d mism=%0d", loads.size(), exp_q.size(), mism()); end
    checks++; if (pops != 3 || errs != 0) begin errors++; $display("FAIL underrun_pops got=%0d err=%0d want=3/0", pops, errs); end
    checks++; if (dones != 1) begin errors++; $display("FAIL underrun_done got=%0d want=1", dones); end
`endif
    fq.delete();
  endtask

  task automatic test_reset_mid();
    int t = 0;
    fill(10);
    start_pkt(4'b1011, 10);
    while (pops < 2 && t < 1000) begin @(negedge clk); t++; end
    checks++; if (pops < 2) begin errors++; $display("FAIL midrst_reach_data got=%0d want=2", pops); end
    rst = 1'b1;
    #1;
    checks++;
    if ({fifo_pop, tx_byte, load_byte, timer_en, timer_clear, eop, tx_busy, tx_done, tx_error} !== 16'h0) begin
      errors++; $display("FAIL midrst_outputs got=%h want=0", {fifo_pop, tx_byte, load_byte, timer_en, timer_clear, eop, tx_busy, tx_done, tx_error});
    end
    @(posedge clk); #1 rst = 1'b0;
    fill(5);
    start_pkt(4'b0011, 5);
    wait_done();
    model(4'b0011, 5);
    checks++; if (mism() != 0) begin errors++; $display("FAIL midrst_loads got_n=%0d want_n=%0d", loads.size(), exp_q.size()); end
    checks++; if (pops != 5 || dones != 1) begin errors++; $display("FAIL midrst_pops got=%0d done=%0d want=5/1", pops, dones); end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_data0_empty();
    test_data1_three();
    test_clamp();
    test_random();
    test_underrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
